// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer.
package store_buffer_pkg;

   localparam int unsigned STORE_BUFFER_DEPTH = 8;
   localparam int unsigned SB_ADDR_WIDTH      = 32;
   localparam int unsigned SB_DATA_WIDTH      = 32;

   // One buffered store at the default address/data widths.
   typedef struct packed {
      logic [SB_ADDR_WIDTH-1:0]   addr;
      logic [SB_DATA_WIDTH-1:0]   data;
      logic [SB_DATA_WIDTH/8-1:0] wstrb;
      logic                       uncached;
   } sb_entry_t;

   // Drain FSM states.
   typedef enum logic {
      StIdle,
      StReq
   } sb_state_e;

endpackage

// File: rtl/sb_fwd_lookup.sv
// Youngest-wins store-to-load byte forwarding network.
// Present only when STORE_BUFFER_FWD_EN is defined.
`ifdef STORE_BUFFER_FWD_EN
module sb_fwd_lookup #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [$clog2(DEPTH)-1:0] head_i,
   input  logic [$clog2(DEPTH):0]   count_i,
   input  logic [ADDR_WIDTH-3:0]    tag_i   [DEPTH],
   input  logic [DATA_WIDTH-1:0]    data_i  [DEPTH],
   input  logic [DATA_WIDTH/8-1:0]  wstrb_i [DEPTH],
   input  logic [ADDR_WIDTH-3:0]    ld_tag_i,
   output logic                     fwd_hit_o,
   output logic [DATA_WIDTH-1:0]    fwd_data_o,
   output logic [DATA_WIDTH/8-1:0]  fwd_mask_o
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;
   localparam int unsigned SW = DATA_WIDTH / 8;

   logic [IW-1:0] idx;

   // Walk oldest to youngest so younger matching bytes overwrite older ones.
   always_comb begin
      fwd_data_o = '0;
      fwd_mask_o = '0;
      idx        = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head_i + IW'(k);
         if ((PW'(k) < count_i) && (tag_i[idx] == ld_tag_i)) begin
            for (int unsigned b = 0; b < SW; b++) begin
               if (wstrb_i[idx][b]) begin
                  fwd_data_o[8*b +: 8] = data_i[idx][8*b +: 8];
                  fwd_mask_o[b]        = 1'b1;
               end
            end
         end
      end
   end

   assign fwd_hit_o = |fwd_mask_o;

endmodule
`endif

// File: rtl/store_buffer.sv
// Store buffer between MEM2/WB and the DCache write port.
// Speculative stores are committed in order by writeback, discarded on flush,
// and committed stores drain over a registered valid/ready port.
// Define STORE_BUFFER_FWD_EN to enable store-to-load forwarding.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH      = STORE_BUFFER_DEPTH,
   parameter int unsigned ADDR_WIDTH = SB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = SB_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enq_valid_i,
   output logic                    enq_ready_o,
   input  logic [ADDR_WIDTH-1:0]   enq_addr_i,
   input  logic [DATA_WIDTH-1:0]   enq_data_i,
   input  logic [DATA_WIDTH/8-1:0] enq_wstrb_i,
   input  logic                    enq_uncached_i,
   input  logic                    store_commit_i,
   input  logic                    flush_i,
   output logic                    wr_valid_o,
   input  logic                    wr_ready_i,
   output logic [ADDR_WIDTH-1:0]   wr_addr_o,
   output logic [DATA_WIDTH-1:0]   wr_data_o,
   output logic [DATA_WIDTH/8-1:0] wr_wstrb_o,
   output logic                    wr_uncached_o,
   output logic                    empty_o,
   output logic                    full_o,
   input  logic [ADDR_WIDTH-1:0]   ld_addr_i,
   output logic                    fwd_hit_o,
   output logic [DATA_WIDTH-1:0]   fwd_data_o,
   output logic [DATA_WIDTH/8-1:0] fwd_mask_o
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;
   localparam int unsigned SW = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data  [DEPTH];
   logic [SW-1:0]         mem_wstrb [DEPTH];
   logic                  mem_unc   [DEPTH];

   logic [PW-1:0]         head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
   logic [PW-1:0]         held, head_inc;
   logic [IW-1:0]         rd_idx;
   sb_state_e             state_q, state_d;
   logic                  wr_valid_q, wr_valid_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [SW-1:0]         wr_wstrb_q, wr_wstrb_d;
   logic                  wr_unc_q, wr_unc_d;
   logic                  enq_fire, commit_fire;

   // Phase bit in the pointer MSB distinguishes full from empty.
   assign held        = tail_q - head_q;
   assign full_o      = (held == PW'(DEPTH));
   assign empty_o     = (tail_q == head_q);
   assign enq_ready_o = !full_o;
   assign enq_fire    = enq_valid_i && !full_o && !flush_i;
   assign commit_fire = store_commit_i && (cmt_q != tail_q);
   assign head_inc    = head_q + PW'(1);

   // Commit and tail pointers; flush rolls tail back to the post-commit point.
   always_comb begin
      cmt_d  = cmt_q + PW'(commit_fire);
      tail_d = tail_q;
      if (flush_i) begin
         tail_d = cmt_d;
      end else if (enq_fire) begin
         tail_d = tail_q + PW'(1);
      end
   end

   // Entry to load into the write port: head when idle, next entry on a handshake.
   assign rd_idx = (state_q == StIdle) ? head_q[IW-1:0] : head_inc[IW-1:0];

   // Drain FSM: registered write port, back-to-back reload while committed work remains.
   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_wstrb_d = wr_wstrb_q;
      wr_unc_d   = wr_unc_q;
      case (state_q)
         StIdle: begin
            if (head_q != cmt_q) begin
               state_d    = StReq;
               wr_valid_d = 1'b1;
               wr_addr_d  = mem_addr[rd_idx];
               wr_data_d  = mem_data[rd_idx];
               wr_wstrb_d = mem_wstrb[rd_idx];
               wr_unc_d   = mem_unc[rd_idx];
            end
         end
         StReq: begin
            if (wr_ready_i) begin
               head_d = head_inc;
               if (head_inc != cmt_q) begin
                  wr_addr_d  = mem_addr[rd_idx];
                  wr_data_d  = mem_data[rd_idx];
                  wr_wstrb_d = mem_wstrb[rd_idx];
                  wr_unc_d   = mem_unc[rd_idx];
               end else begin
                  wr_valid_d = 1'b0;
                  state_d    = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Pointer, FSM and write-port registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q     <= '0;
         cmt_q      <= '0;
         tail_q     <= '0;
         state_q    <= StIdle;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_wstrb_q <= '0;
         wr_unc_q   <= 1'b0;
      end else begin
         head_q     <= head_d;
         cmt_q      <= cmt_d;
         tail_q     <= tail_d;
         state_q    <= state_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_wstrb_q <= wr_wstrb_d;
         wr_unc_q   <= wr_unc_d;
      end
   end

   // Entry storage; contents are qualified by the pointers so no reset is needed.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         mem_addr[tail_q[IW-1:0]]  <= enq_addr_i;
         mem_data[tail_q[IW-1:0]]  <= enq_data_i;
         mem_wstrb[tail_q[IW-1:0]] <= enq_wstrb_i;
         mem_unc[tail_q[IW-1:0]]   <= enq_uncached_i;
      end
   end

   assign wr_valid_o    = wr_valid_q;
   assign wr_addr_o     = wr_addr_q;
   assign wr_data_o     = wr_data_q;
   assign wr_wstrb_o    = wr_wstrb_q;
   assign wr_uncached_o = wr_unc_q;

`ifdef STORE_BUFFER_FWD_EN
   logic [ADDR_WIDTH-3:0] tag [DEPTH];
   logic                  unused_ld_lsbs;

   // Word tags of every slot; the lookup masks out slots that are not held.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         tag[i] = mem_addr[i][ADDR_WIDTH-1:2];
      end
   end

   assign unused_ld_lsbs = ^ld_addr_i[1:0];

   sb_fwd_lookup #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fwd (
      .head_i     (head_q[IW-1:0]),
      .count_i    (held),
      .tag_i      (tag),
      .data_i     (mem_data),
      .wstrb_i    (mem_wstrb),
      .ld_tag_i   (ld_addr_i[ADDR_WIDTH-1:2]),
      .fwd_hit_o  (fwd_hit_o),
      .fwd_data_o (fwd_data_o),
      .fwd_mask_o (fwd_mask_o)
   );
`else
   logic unused_ld_addr;

   assign unused_ld_addr = ^ld_addr_i;
   assign fwd_hit_o      = 1'b0;
   assign fwd_data_o     = '0;
   assign fwd_mask_o     = '0;
`endif

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the MEM2/WB boundary and the DCache write port.
- Holds speculative stores from the memory stage and marks the oldest one committed on each store-commit pulse from writeback.
- Discards uncommitted stores when writeback flushes; drains committed stores in order to the DCache/AXI write port over a valid/ready handshake.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ADDR_WIDTH, 32, store physical address width.
- DATA_WIDTH, 32, store data width; byte-strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- enq_valid_i  in  1  memory stage presents a store
- enq_ready_o  out  1  entry available (= !full_o)
- enq_addr_i  in  ADDR_WIDTH  store physical address
- enq_data_i  in  DATA_WIDTH  byte-aligned store data
- enq_wstrb_i  in  DATA_WIDTH/8  byte strobes
- enq_uncached_i  in  1  store targets uncached space
- store_commit_i  in  1  writeback commit pulse; commits the oldest uncommitted entry
- flush_i  in  1  writeback flush; discards all uncommitted entries
- wr_valid_o  out  1  committed store offered to the DCache
- wr_ready_i  in  1  DCache accepts the store
- wr_addr_o  out  ADDR_WIDTH  offered store address
- wr_data_o  out  DATA_WIDTH  offered store data
- wr_wstrb_o  out  DATA_WIDTH/8  offered store strobes
- wr_uncached_o  out  1  offered store is uncached
- empty_o  out  1  no entries held
- full_o  out  1  DEPTH entries held
- ld_addr_i  in  ADDR_WIDTH  load lookup address (feature only)
- fwd_hit_o  out  1  at least one byte forwarded (feature only)
- fwd_data_o  out  DATA_WIDTH  forwarded bytes (feature only)
- fwd_mask_o  out  DATA_WIDTH/8  forwarded-byte mask (feature only)

Behaviour:
- Reset and flush:
  - Reset is asynchronous, active-high; reset logic is clocked by clk.
  - On reset, pointers head, cmt and tail are 0; the drain FSM is in IDLE; all wr_* outputs are 0; empty_o=1, full_o=0.
- Pointers and status:
  - Pointers are log2(DEPTH)+1 bits and wrap with an MSB phase bit.
  - Region head..cmt holds committed entries; region cmt..tail holds speculative entries.
  - full_o = (tail - head == DEPTH). empty_o = (tail == head).
- Enqueue:
  - An entry is written and tail increments at the clock edge when enq_valid_i && enq_ready_o.
  - An enqueue in the same cycle as flush_i is dropped.
- Commit:
  - store_commit_i increments cmt if cmt != tail at the start of the cycle.
  - An entry enqueued in the same cycle cannot be committed in that cycle.
  - A commit with no uncommitted entry is ignored.
- Flush:
  - flush_i sets tail <= cmt_next, i.e. cmt after applying any same-cycle commit.
  - Committed entries and an in-flight drain are never affected.
- Drain FSM states: IDLE, REQ.
  - IDLE: if head != cmt, load wr_* registers from entry[head] and go to REQ; wr_valid_o=1 in the next cycle.
  - REQ: wr_* outputs are registered and held stable until wr_ready_i.
  - On the handshake, head increments. If another committed entry remains, it is loaded back-to-back and the FSM stays in REQ; otherwise wr_valid_o=0 and the FSM returns to IDLE.
- Latency:
  - Commit registered at edge N means wr_valid_o is high after edge N+1 when the buffer was idle.
  - Steady-state throughput is 1 store/cycle while wr_ready_i is held high.
- Concurrency and pointer rules:
  - Enqueue, commit, drain and flush may all occur in one cycle; each pointer updates independently under the rules above.
  - full_o is computed from the registered pointers; a drain in the same cycle does not free space until the next cycle.
- Width rule: wr_wstrb_o is forwarded as given; there is no merging or coalescing.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined:
  - Combinational store-to-load forwarding.
  - Every held entry, committed or speculative, whose address matches ld_addr_i on ADDR_WIDTH-1:2 contributes its strobed bytes.
  - Per byte, the youngest matching entry wins.
  - Outputs: fwd_mask_o = OR of the winning strobes; fwd_data_o = the selected bytes; fwd_hit_o = |fwd_mask_o.
  - The entry currently being drained still participates until its handshake.
- Undefined: lookup logic is absent; fwd_hit_o, fwd_data_o and fwd_mask_o are tied 0; ld_addr_i is ignored.

Decomposition:
- core_types: sb_entry_t struct {addr, data, wstrb, uncached}.
- core_config: STORE_BUFFER_DEPTH default.
- One sub-module: sb_fwd_lookup, the youngest-wins byte-select network, instantiated only under STORE_BUFFER_FWD_EN.

Test Plan:
- Basic drain:
  - Stimulus: enqueue addr 0x1000, data 0xDEADBEEF, wstrb 0xF; commit next cycle; wr_ready_i=1.
  - Response: wr_valid_o one cycle after the commit edge with the same fields; empty_o=1 after the handshake.
- Flush discards speculative entries:
  - Stimulus: enqueue 3 stores (0x10, 0x14, 0x18); commit 1; flush.
  - Response: only 0x10 is drained; empty_o=1 afterwards; no further wr_valid_o.
- Full and backpressure:
  - Stimulus: enqueue 8 stores with wr_ready_i=0.
  - Response: full_o=1 and enq_ready_o=0; a 9th enqueue is not written.
  - Stimulus continued: commit all 8, then raise wr_ready_i.
  - Response: 8 stores drain in order over 8 consecutive cycles; wr_* stable while wr_ready_i=0.
- Simultaneous commit and flush:
  - Stimulus: 2 speculative entries; assert commit and flush in the same cycle.
  - Response: entry 0 is retained and drained; entry 1 is discarded.
- Asynchronous reset mid-drain:
  - Stimulus: assert rst while wr_valid_o=1 between clock edges.
  - Response: wr_valid_o=0 immediately; empty_o=1; no handshake completes.
- Forwarding (STORE_BUFFER_FWD_EN):
  - Stimulus: store 0x11223344 strobe 0xF to 0x20, then store 0x0000AA00 strobe 0x2 to 0x20; lookup ld_addr_i=0x22.
  - Response: fwd_data_o=0x1122AA44, fwd_mask_o=0xF, fwd_hit_o=1.
